// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer for a cascaded BCD stopwatch.
// An internal prescaler produces the per-tick count enable; a NUM_DIGITS-wide
// BCD count and a lap-freeze register drive the display value.
// Optional feature macro: STOPWATCH_AUTOSTOP_EN (saturate at all 9s and force
// PAUSE on the overflow tick instead of wrapping to zero).
//
// Pulse inputs (start_stop, lap, clr) are single-cycle strobes sampled on the
// rising edge; there is no valid/ready handshake in this block. When pulses
// coincide the priority is clr > start_stop > lap.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clr,
  output logic                    count_en,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow,
  output logic [1:0]              dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [PW-1:0]             r_presc;
  logic [4*NUM_DIGITS-1:0]   r_count;
  logic [4*NUM_DIGITS-1:0]   r_lap;
  logic                      r_overflow;

  logic                      w_running;
  logic                      w_tick;
  logic                      w_all9;
  logic                      w_sat;
  logic                      w_clr_all;
  logic                      w_clr_ovf;
  logic                      w_lap_load;
  logic [NUM_DIGITS:0]       w_carry;
  logic [4*NUM_DIGITS-1:0]   w_count_inc;

  assign w_running = (r_state == RUN) || (r_state == LAP);
  assign w_tick    = w_running && (r_presc == PRESC_MAX);
  assign w_all9    = w_carry[NUM_DIGITS];
  assign w_sat     = w_all9 && r_overflow;
  // clr only has an effect when the watch is stopped
  assign w_clr_all = clr && (r_state == PAUSE);
  assign w_clr_ovf = clr && ((r_state == IDLE) || (r_state == PAUSE));
  // the lap register captures the pre-increment count on entry to LAP
  assign w_lap_load = (r_state == RUN) && (w_state_next == LAP);

  // BCD ripple increment: digit i advances when every lower digit is 9
  always_comb begin
    w_carry     = '0;
    w_count_inc = r_count;
    w_carry[0]  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry[i]) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
        end
      end
      w_carry[i+1] = w_carry[i] && (r_count[4*i +: 4] == 4'd9);
    end
  end

  // next-state decode with priority clr > start_stop > lap
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (clr)             w_state_next = IDLE;
        else if (start_stop) w_state_next = RUN;
      end
      RUN: begin
        if (start_stop)      w_state_next = PAUSE;
        else if (lap)        w_state_next = LAP;
      end
      LAP: begin
        if (start_stop)      w_state_next = PAUSE;
        else if (lap)        w_state_next = RUN;
      end
      PAUSE: begin
        if (clr)             w_state_next = IDLE;
`ifdef STOPWATCH_AUTOSTOP_EN
        else if (start_stop && !w_sat) w_state_next = RUN;
`else
        else if (start_stop) w_state_next = RUN;
`endif
      end
      default: w_state_next = IDLE;
    endcase
`ifdef STOPWATCH_AUTOSTOP_EN
    // the overflow tick stops the watch; leaving LAP shows the live count
    if (w_tick && w_all9) w_state_next = PAUSE;
`endif
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // prescaler: advances only while running, holds in PAUSE to keep phase
  always_ff @(posedge clk) begin
    if (reset || w_clr_all) begin
      r_presc <= '0;
    end else if (w_running) begin
      if (r_presc == PRESC_MAX) r_presc <= '0;
      else                      r_presc <= r_presc + 1'b1;
    end
  end

  // BCD count: increments on each tick, wraps or saturates on all 9s
  always_ff @(posedge clk) begin
    if (reset || w_clr_all) begin
      r_count <= '0;
    end else if (w_tick) begin
`ifdef STOPWATCH_AUTOSTOP_EN
      if (!w_all9) r_count <= w_count_inc;
`else
      r_count <= w_count_inc;
`endif
    end
  end

  // sticky overflow flag, cleared by clr while stopped
  always_ff @(posedge clk) begin
    if (reset || w_clr_ovf)     r_overflow <= 1'b0;
    else if (w_tick && w_all9)  r_overflow <= 1'b1;
  end

  // lap-freeze register
  always_ff @(posedge clk) begin
    if (reset)           r_lap <= '0;
    else if (w_lap_load) r_lap <= r_count;
  end

  assign count_en   = w_tick;
  assign running    = w_running;
  assign lap_active = (r_state == LAP);
  assign digits     = (r_state == LAP) ? r_lap : r_count;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, NUM_DIGITS=2.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int NUM_DIGITS = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                    start_stop = 1'b0;
  logic                    lap = 1'b0;
  logic                    clr = 1'b0;
  logic                    count_en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    lap_active;
  logic                    overflow;
  logic [1:0]              dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clr        (clr),
    .count_en   (count_en),
    .digits     (digits),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // driver tasks
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic ss, input logic lp, input logic cl);
    start_stop = ss;
    lap        = lp;
    clr        = cl;
    step(1);
    start_stop = 1'b0;
    lap        = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held two cycles
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_digits", 32'(digits), 32'h00);
    check("rst_running", 32'(running), 0);
    check("rst_count_en", 32'(count_en), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_lap_active", 32'(lap_active), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // start: count_en on every 4th RUN cycle, 0x10 after ten ticks
    pulse(1'b1, 1'b0, 1'b0);
    check("run_state", 32'(dbg_state), 32'(S_RUN));
    check("run_running", 32'(running), 1);
    for (int i = 1; i <= 40; i++) begin
      check($sformatf("run_cen_c%0d", i), 32'(count_en), 32'((i % 4) == 0));
      step(1);
    end
    check("run_digits_10", 32'(digits), 32'h10);

    // clr while running is ignored
    pulse(1'b0, 1'b0, 1'b1);
    check("clr_run_digits", 32'(digits), 32'h10);
    check("clr_run_state", 32'(dbg_state), 32'(S_RUN));

    // pause, then clr + start_stop together -> IDLE, zeroed
    pulse(1'b1, 1'b0, 1'b0);
    check("pause_state", 32'(dbg_state), 32'(S_PAUSE));
    pulse(1'b1, 1'b0, 1'b1);
    check("clrss_state", 32'(dbg_state), 32'(S_IDLE));
    check("clrss_digits", 32'(digits), 32'h00);
    check("clrss_overflow", 32'(overflow), 0);
    check("clrss_running", 32'(running), 0);

    // run to 0x07 and pause with prescaler = 2
    pulse(1'b1, 1'b0, 1'b0);
    step(29);
    check("pre_pause_digits", 32'(digits), 32'h07);
    pulse(1'b1, 1'b0, 1'b0);
    check("paused_running", 32'(running), 0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("paused_cen_%0d", i), 32'(count_en), 0);
      check($sformatf("paused_digits_%0d", i), 32'(digits), 32'h07);
      step(1);
    end

    // resume keeps phase: tick on 2nd RUN cycle
    pulse(1'b1, 1'b0, 1'b0);
    check("resume_cen_c1", 32'(count_en), 0);
    step(1);
    check("resume_cen_c2", 32'(count_en), 1);
    step(1);
    check("resume_digits_08", 32'(digits), 32'h08);

    // lap at 0x23 freezes the display
    step(60);
    check("prelap_digits", 32'(digits), 32'h23);
    pulse(1'b0, 1'b1, 1'b0);
    check("lap_active", 32'(lap_active), 1);
    check("lap_running", 32'(running), 1);
    check("lap_digits", 32'(digits), 32'h23);
    step(11);
    check("lap_frozen", 32'(digits), 32'h23);
    pulse(1'b0, 1'b1, 1'b0);
    check("unlap_active", 32'(lap_active), 0);
    check("unlap_digits", 32'(digits), 32'h26);

    // lap entered on a tick cycle captures the pre-increment count
    step(2);
    check("laptick_cen", 32'(count_en), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("laptick_digits", 32'(digits), 32'h26);
    // start_stop in LAP -> PAUSE with live display
    pulse(1'b1, 1'b0, 1'b0);
    check("lappause_state", 32'(dbg_state), 32'(S_PAUSE));
    check("lappause_digits", 32'(digits), 32'h27);
    check("lappause_lap_active", 32'(lap_active), 0);

    // run up to 0x99, then the overflow tick
    pulse(1'b1, 1'b0, 1'b0);
    step(287);
    check("at_99", 32'(digits), 32'h99);
    step(3);
    check("ovf_tick_cen", 32'(count_en), 1);
    step(1);
    check("ovf_flag", 32'(overflow), 1);
`ifdef STOPWATCH_AUTOSTOP_EN
    check("ovf_digits", 32'(digits), 32'h99);
    check("ovf_running", 32'(running), 0);
    check("ovf_state", 32'(dbg_state), 32'(S_PAUSE));
    pulse(1'b1, 1'b0, 1'b0);
    check("sat_ss_state", 32'(dbg_state), 32'(S_PAUSE));
    check("sat_ss_digits", 32'(digits), 32'h99);
`else
    check("ovf_digits", 32'(digits), 32'h00);
    check("ovf_running", 32'(running), 1);
    step(4);
    check("wrap_continue", 32'(digits), 32'h01);
    check("wrap_ovf_sticky", 32'(overflow), 1);
    pulse(1'b1, 1'b0, 1'b0);
    check("wrap_pause_ovf", 32'(overflow), 1);
`endif
    pulse(1'b0, 1'b0, 1'b1);
    check("recover_state", 32'(dbg_state), 32'(S_IDLE));
    check("recover_overflow", 32'(overflow), 0);
    check("recover_digits", 32'(digits), 32'h00);

    // synchronous reset overrides coincident pulses
    pulse(1'b1, 1'b0, 1'b0);
    step(5);
    check("prereset_digits", 32'(digits), 32'h01);
    reset = 1'b1;
    start_stop = 1'b1;
    lap = 1'b1;
    step(1);
    reset = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    check("midrst_digits", 32'(digits), 32'h00);
    check("midrst_running", 32'(running), 0);
    check("midrst_count_en", 32'(count_en), 0);
    step(4);
    check("midrst_hold_state", 32'(dbg_state), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/pause/lap/clear sequencer for a chain of cascaded BCD decade digits.
- Contains an internal prescaler that generates the per-tick count enable (the carry-in of the least-significant digit).
- Keeps a NUM_DIGITS-wide BCD count and a lap-freeze register, and drives the display value.
- Sits between the front-panel pulse inputs and the 7-segment decoders.

Parameters:
- TICK_DIV, 10, clock cycles per count increment (>=1).
- NUM_DIGITS, 4, number of BCD digits (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start_stop  in  1  single-cycle pulse: toggles run/pause.
- lap  in  1  single-cycle pulse: freezes or unfreezes the display while counting.
- clr  in  1  single-cycle pulse: clears the count (honoured only in IDLE/PAUSE).
- count_en  out  1  tick strobe, i.e. carry-in to digit 0.
- digits  out  4*NUM_DIGITS  displayed BCD value; digit 0 in [3:0].
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- overflow  out  1  sticky wrap flag.

Behaviour:
- Reset:
  - state = IDLE; prescaler, count and lap register = 0.
  - digits = 0, count_en = 0, running = 0, lap_active = 0, overflow = 0.
- States: IDLE, RUN, LAP, PAUSE.
- Input priority when pulses coincide: clr > start_stop > lap. Pulses with no effect in the current state are ignored.
- Transitions:
  - IDLE: start_stop -> RUN; clr -> IDLE and clears overflow.
  - RUN: start_stop -> PAUSE; lap -> LAP; clr ignored.
  - LAP: start_stop -> PAUSE (display returns to live); lap -> RUN; clr ignored.
  - PAUSE: start_stop -> RUN; clr -> IDLE, zeroing count, prescaler and overflow; lap ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while running, then wraps to 0.
  - Holds its value in PAUSE, so resume keeps the phase.
  - Zeroed by clr and by reset.
- count_en:
  - Combinational: running && prescaler == TICK_DIV-1.
  - With TICK_DIV = 1 it is high on every running cycle.
  - Never high in IDLE or PAUSE.
- Count update:
  - Registered at the same edge on which count_en is high; new value visible the next cycle.
  - Digit i increments when count_en is high and all lower digits == 9.
  - Each digit wraps 9 -> 0; legal digit values are 0..9 only.
- Overflow:
  - When all digits == 9 and count_en is high, the count wraps to all-zero.
  - overflow is set and held until clr in IDLE/PAUSE, or reset.
- Lap register:
  - Loaded on the edge entering LAP with the pre-increment count, including when a count_en occurs in the same cycle.
  - digits = lap register in LAP, live count otherwise.
- Reset mid-operation: synchronous reset overrides every pulse; next cycle equals the post-reset state.

Optional Feature:
- Macro: STOPWATCH_AUTOSTOP_EN.
- Defined:
  - On the overflow tick the count saturates at all 9s instead of wrapping.
  - overflow is set and the state is forced to PAUSE. In LAP, the display also returns to live.
  - Further start_stop pulses while saturated (all 9s and overflow set) keep the state in PAUSE; only clr recovers.
- Undefined: count wraps to 0, overflow sticks, counting continues.

Test Plan (TICK_DIV=4, NUM_DIGITS=2):
- Reset held 2 cycles, then released -> digits=0x00, running=0, count_en=0, overflow=0.
- start_stop pulse, then 40 cycles -> count_en high every 4th cycle (first on the 4th RUN cycle); digits=0x10 after the 10th tick.
- Pause with digits=0x07 and prescaler=2, idle 20 cycles -> digits stays 0x07, count_en stays 0.
  - Resume -> count_en high on the 2nd RUN cycle; digits=0x08 the cycle after.
- lap at digits=0x23 -> digits frozen at 0x23 and running=1.
  - 12 cycles later, second lap -> lap_active=0, digits=0x26 live.
- Run to 0x99, next tick:
  - Macro undefined -> digits=0x00, overflow=1, running=1.
  - STOPWATCH_AUTOSTOP_EN defined -> digits=0x99, overflow=1, running=0.
- Edge cases:
  - clr in RUN -> ignored, count continues.
  - clr and start_stop in the same cycle in PAUSE -> IDLE, digits=0x00, overflow=0.
